wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter: RA_W, 5, register-file address width.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low; asserting it clears all state immediately, independent of clk.
REQ-004 SHALL have port: in_valid  in  1  MEM stage presents a valid instruction this cycle.
REQ-005 SHALL have port: stall  in  1  hold current WB register contents.
REQ-006 SHALL have port: flush  in  1  replace captured instruction with bubble.
REQ-007 SHALL have port: RW  in  1  instruction writes a register.
REQ-008 SHALL have port: MD  in  1  1 = write back load data, 0 = ALU result.
REQ-009 SHALL have port: DA  in  RA_W  destination register.
REQ-010 SHALL have port: alu_result  in  32  ALU result, which is also the MEM address.
REQ-011 SHALL have port: readData  in  32  word from MEM stage (combinational read).
REQ-012 SHALL have port: ld_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-013 SHALL have port: ld_signed  in  1  sign-extend sub-word loads.
REQ-014 SHALL have port: rf_we  out  1  register-file write enable.
REQ-015 SHALL have port: rf_wa  out  RA_W  register-file write address.
REQ-016 SHALL have port: rf_wd  out  32  register-file write data.
REQ-017 SHALL have port: misalign  out  1  registered one-cycle flag for a misaligned or reserved load.
REQ-018 SHALL have port (only when RETIRE_CNT_EN is defined): retire_cnt  out  32  retired-instruction count.

Function
REQ-019 SHALL capture inputs on the clk rising edge; outputs are registered, giving 1-cycle latency from in_valid to rf_we.
REQ-020 SHALL select the load byte by alu_result[1:0] when ld_size=00, and the halfword by alu_result[1] when ld_size=01; ld_size=10 passes readData unchanged.
REQ-021 SHALL sign-extend sub-word loads when ld_signed=1 and zero-extend otherwise.
REQ-022 SHALL set write data to the formatted load data when MD=1, else to alu_result.
REQ-023 SHALL flag a load (MD=1) as misaligned when: ld_size=01 with alu_result[0]=1, or ld_size=10 with alu_result[1:0]!=00, or ld_size=11.
REQ-024 SHALL, on a misaligned load, capture misalign=1 and rf_we=0 for that instruction.
REQ-025 SHALL compute next rf_we = in_valid & RW & (DA!=0) & ~misaligned; writes to R0 are always suppressed.
REQ-026 SHALL hold all outputs and the counter unchanged on a stall=1 edge, which also ignores inputs.
REQ-027 SHALL load a bubble on a flush=1 edge: rf_we=0, misalign=0, rf_wa=0, rf_wd=0.
REQ-028 SHALL give flush priority over stall when both are asserted on the same edge.
REQ-029 SHALL capture a bubble when in_valid=0 and neither stall nor flush is asserted.

Reset
REQ-030 SHALL, while reset=0, force rf_we=0, rf_wa=0, rf_wd=0, misalign=0 and retire_cnt=0.
REQ-031 SHALL discard an instruction in flight when reset asserts mid-operation; the first capture occurs on the first rising edge with reset=1.

Configuration
REQ-032 SHALL, with RETIRE_CNT_EN defined, increment retire_cnt by 1 on each edge that captures in_valid=1 with no stall and no flush, including R0 writes and misaligned loads; the count wraps 0xFFFFFFFF to 0.
REQ-033 SHALL, without RETIRE_CNT_EN, omit the retire_cnt port and its counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: signed byte load, readData=0x12AB80FF, alu_result=0x00000005, ld_size=00, ld_signed=1, MD=1, RW=1, DA=3 -> next cycle rf_we=1, rf_wa=3, rf_wd=0xFFFFFF80.
REQ-035 SHALL cover: misaligned word load, ld_size=10, alu_result=0x00000006, MD=1, RW=1, DA=7 -> next cycle misalign=1 and rf_we=0; the following idle cycle misalign=0.
REQ-036 SHALL cover: ALU write to R0, MD=0, DA=0, alu_result=0x1234 -> rf_we=0; retire_cnt increments by 1 when RETIRE_CNT_EN is defined.
REQ-037 SHALL cover: stall=1 and flush=1 on the same edge after a valid write to R5 -> rf_we=0 and retire_cnt unchanged.
REQ-038 SHALL cover: reset=0 asserted between edges while rf_we=1 -> all outputs are 0 before the next edge.
REQ-039 SHALL cover: retire_cnt preset to 0xFFFFFFFF by 2^32 retirements, or by a forced-value bench variant, plus one valid instruction -> retire_cnt=0.

Source files
------------

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - pipeline write-back stage: load formatting, misalign detection, registered RF write port
// Optional retire counter enabled by defining RETIRE_CNT_EN.
module wb_stage #(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic            RW,
    input  logic            MD,
    input  logic [RA_W-1:0] DA,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     readData,
    input  logic [1:0]      ld_size,
    input  logic            ld_signed,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_wa,
    output logic [31:0]     rf_wd,
`ifdef RETIRE_CNT_EN
    output logic [31:0]     retire_cnt,
`endif
    output logic            misalign
);

    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ld_data;
    logic [31:0]     w_wd;
    logic            w_misaligned;
    logic            w_we;

    logic            r_we;
    logic [RA_W-1:0] r_wa;
    logic [31:0]     r_wd;
    logic            r_misalign;

    always_comb begin
        w_byte = readData[7:0];
        case (alu_result[1:0])
            2'b00:   w_byte = readData[7:0];
            2'b01:   w_byte = readData[15:8];
            2'b10:   w_byte = readData[23:16];
            default: w_byte = readData[31:24];
        endcase
        w_half = alu_result[1] ? readData[31:16] : readData[15:0];
        case (ld_size)
            2'b00:   w_ld_data = {{24{ld_signed & w_byte[7]}}, w_byte};
            2'b01:   w_ld_data = {{16{ld_signed & w_half[15]}}, w_half};
            default: w_ld_data = readData;
        endcase
    end

    // Only real loads can be misaligned; ALU results carry no alignment rule.
    assign w_misaligned = in_valid & MD &
                          (((ld_size == 2'b01) & alu_result[0]) |
                           ((ld_size == 2'b10) & (alu_result[1:0] != 2'b00)) |
                           (ld_size == 2'b11));
    assign w_wd = MD ? w_ld_data : alu_result;
    assign w_we = in_valid & RW & (DA != '0) & ~w_misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we       <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
            r_misalign <= 1'b0;
        end else if (flush || (!stall && !in_valid)) begin
            r_we       <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
            r_misalign <= 1'b0;
        end else if (!stall) begin
            r_we       <= w_we;
            r_wa       <= DA;
            r_wd       <= w_wd;
            r_misalign <= w_misaligned;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    // Every accepted instruction retires, even R0 writes and faulting loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (in_valid && !stall && !flush) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

    assign rf_we    = r_we;
    assign rf_wa    = r_wa;
    assign rf_wd    = r_wd;
    assign misalign = r_misalign;

endmodule
